// File: rtl/gpu_pkg.sv
// ----------------------------------------------------------------------------
// gpu_pkg
// Shared definitions for the sprite-cluster write path.
//   cluster_wr_state_t : write-sequencer states
//   SPRITE_FIELDS      : words per sprite descriptor
//   F_SX .. F_STH      : word index of each descriptor field
//   texture_base()     : first texture word address inside a cluster
// ----------------------------------------------------------------------------
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPR   = 2'd1,
        FILL  = 2'd2,
        DRAIN = 2'd3
    } cluster_wr_state_t;

    localparam int SPRITE_FIELDS = 6;

    localparam int F_SX  = 0;
    localparam int F_SY  = 1;
    localparam int F_STX = 2;
    localparam int F_STY = 3;
    localparam int F_STW = 4;
    localparam int F_STH = 5;

    // Texture storage starts right after the last sprite descriptor.
    function automatic int texture_base(input int cluster_size);
        return cluster_size * SPRITE_FIELDS;
    endfunction

endpackage

// File: rtl/cluster_write_ctrl.sv
// ----------------------------------------------------------------------------
// cluster_write_ctrl
// Write-port sequencer for one sprite cluster. Turns sprite-descriptor
// updates (6 words) and texture block fills (streamed from a source RAM)
// into single-word writes on waddr/wdata/wen. New commands only start
// while vblank is high; a started command always runs to completion.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   vblank              : display outside visible area (start gate)
//   cmd_*               : sprite command (valid/ready, slot, six fields)
//   fill_*              : texture fill command (valid/ready, base, len, src)
//   src_addr/ren/rdata  : source RAM read port (1-cycle read latency)
//   waddr/wdata/wen     : cluster write bus (registered)
//   busy                : sequencer not idle
// ----------------------------------------------------------------------------
module cluster_write_ctrl
    import gpu_pkg::*;
#(
    parameter int CLUSTER_SIZE = 10,
    parameter int TEXTURE_SIZE = 4096,
    parameter int ADDR_WIDTH   = 16,
    parameter int INT_WIDTH    = 16,
    parameter int COLOR_WIDTH  = 12,
    parameter int LEN_WIDTH    = 13
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            vblank,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [$clog2(CLUSTER_SIZE)-1:0] cmd_index,
    input  logic [INT_WIDTH-1:0]            cmd_sx,
    input  logic [INT_WIDTH-1:0]            cmd_sy,
    input  logic [INT_WIDTH-1:0]            cmd_stx,
    input  logic [INT_WIDTH-1:0]            cmd_sty,
    input  logic [INT_WIDTH-1:0]            cmd_stw,
    input  logic [INT_WIDTH-1:0]            cmd_sth,
    input  logic                            fill_valid,
    output logic                            fill_ready,
    input  logic [LEN_WIDTH-1:0]            fill_base,
    input  logic [LEN_WIDTH-1:0]            fill_len,
    input  logic [ADDR_WIDTH-1:0]           fill_src,
    output logic [ADDR_WIDTH-1:0]           src_addr,
    output logic                            src_ren,
    input  logic [COLOR_WIDTH-1:0]          src_rdata,
    output logic [ADDR_WIDTH-1:0]           waddr,
    output logic [INT_WIDTH-1:0]            wdata,
    output logic                            wen,
    output logic                            busy
);

    // One extra bit so base+i never wraps back into the texture range.
    localparam int OFF_W = LEN_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] TEX_BASE = ADDR_WIDTH'(texture_base(CLUSTER_SIZE));

    cluster_wr_state_t      state_q;
    logic [INT_WIDTH-1:0]   fld_q [SPRITE_FIELDS];
    logic [ADDR_WIDTH-1:0]  spr_base_q;
    logic [2:0]             k_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   rd_cnt_q;
    logic                   drain_q;
    logic [OFF_W-1:0]       off_p0_q;
    logic [OFF_W-1:0]       off_p1_q;
    logic                   vld_p1_q;

    logic cmd_acc;
    logic fill_acc;

    // Sprite commands take fixed priority over fills.
    assign cmd_ready  = (state_q == IDLE) && vblank;
    assign fill_ready = (state_q == IDLE) && vblank && !cmd_valid;
    assign cmd_acc    = cmd_valid && cmd_ready;
    assign fill_acc   = fill_valid && fill_ready;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            waddr    <= '0;
            wdata    <= '0;
            wen      <= 1'b0;
            src_addr <= '0;
            src_ren  <= 1'b0;
            vld_p1_q <= 1'b0;
            k_q      <= '0;
            rd_cnt_q <= '0;
            drain_q  <= 1'b0;
        end else begin
            wen <= 1'b0;

            // Fill pipeline: p0 = read issued this cycle, p1 = read data
            // arriving this cycle; the write is registered one cycle later.
            vld_p1_q <= src_ren;
            off_p1_q <= off_p0_q;
            if (vld_p1_q) begin
                // Out-of-range texels are dropped but keep their time slot.
                wen   <= (off_p1_q < OFF_W'(TEXTURE_SIZE));
                waddr <= TEX_BASE + ADDR_WIDTH'(off_p1_q);
                wdata <= INT_WIDTH'(src_rdata);
            end

            case (state_q)
                IDLE: begin
                    if (cmd_acc) begin
                        // Illegal slots are consumed without any write.
                        if (32'(cmd_index) < CLUSTER_SIZE) begin
                            fld_q[F_SX]  <= cmd_sx;
                            fld_q[F_SY]  <= cmd_sy;
                            fld_q[F_STX] <= cmd_stx;
                            fld_q[F_STY] <= cmd_sty;
                            fld_q[F_STW] <= cmd_stw;
                            fld_q[F_STH] <= cmd_sth;
                            spr_base_q   <= ADDR_WIDTH'(cmd_index) * ADDR_WIDTH'(SPRITE_FIELDS);
                            // Field 0 goes out straight from the command inputs.
                            wen          <= 1'b1;
                            waddr        <= ADDR_WIDTH'(cmd_index) * ADDR_WIDTH'(SPRITE_FIELDS);
                            wdata        <= cmd_sx;
                            k_q          <= 3'd1;
                            state_q      <= SPR;
                        end
                    end else if (fill_acc) begin
                        if (fill_len != '0) begin
                            src_ren  <= 1'b1;
                            src_addr <= fill_src;
                            off_p0_q <= OFF_W'(fill_base);
                            rd_cnt_q <= LEN_WIDTH'(1);
                            len_q    <= fill_len;
                            state_q  <= FILL;
                        end
                    end
                end

                SPR: begin
                    if (k_q == 3'(SPRITE_FIELDS)) begin
                        state_q <= IDLE;
                    end else begin
                        wen   <= 1'b1;
                        waddr <= spr_base_q + ADDR_WIDTH'(k_q);
                        wdata <= fld_q[k_q];
                        k_q   <= k_q + 3'd1;
                    end
                end

                FILL: begin
                    if (rd_cnt_q == len_q) begin
                        src_ren <= 1'b0;
                        drain_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        src_ren  <= 1'b1;
                        src_addr <= src_addr + ADDR_WIDTH'(1);
                        off_p0_q <= off_p0_q + OFF_W'(1);
                        rd_cnt_q <= rd_cnt_q + LEN_WIDTH'(1);
                    end
                end

                DRAIN: begin
                    // Two cycles let the last read reach the write bus.
                    if (drain_q) begin
                        state_q <= IDLE;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cluster_write_ctrl.sv
module tb_cluster_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblank;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_index;
    logic [15:0] cmd_sx, cmd_sy, cmd_stx, cmd_sty, cmd_stw, cmd_sth;
    logic        fill_valid;
    logic        fill_ready;
    logic [12:0] fill_base;
    logic [12:0] fill_len;
    logic [15:0] fill_src;
    logic [15:0] src_addr;
    logic        src_ren;
    logic [11:0] src_rdata = 12'h000;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        wen;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cluster_write_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .vblank     (vblank),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_index  (cmd_index),
        .cmd_sx     (cmd_sx),
        .cmd_sy     (cmd_sy),
        .cmd_stx    (cmd_stx),
        .cmd_sty    (cmd_sty),
        .cmd_stw    (cmd_stw),
        .cmd_sth    (cmd_sth),
        .fill_valid (fill_valid),
        .fill_ready (fill_ready),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_src   (fill_src),
        .src_addr   (src_addr),
        .src_ren    (src_ren),
        .src_rdata  (src_rdata),
        .waddr      (waddr),
        .wdata      (wdata),
        .wen        (wen),
        .busy       (busy)
    );

    // Source RAM model: word at address a holds 0xA00 + a[7:0], one-cycle latency.
    always @(posedge clk) begin
        if (src_ren) src_rdata <= 12'hA00 + {4'h0, src_addr[7:0]};
    end

    typedef struct {
        bit          is_fill;
        logic [3:0]  idx;
        logic [15:0] fstep;
        logic [12:0] base;
        logic [12:0] len;
        logic [15:0] src;
        int          exp_nwr;
        logic [15:0] exp_first;
    } vec_t;

    // One cycle's comparison of every output; ready expectations follow from
    // the expected busy plus the inputs currently driven.
    task automatic step_check(input string tag, input logic e_wen, input logic [15:0] e_waddr,
                              input logic [15:0] e_wdata, input logic e_ren,
                              input logic [15:0] e_saddr, input logic e_busy);
        logic e_cr, e_fr;
        bit   ok;
        e_cr = !e_busy && vblank;
        e_fr = e_cr && !cmd_valid;
        ok = (wen === e_wen) && (!e_wen || (waddr === e_waddr && wdata === e_wdata)) &&
             (src_ren === e_ren) && (!e_ren || src_addr === e_saddr) &&
             (busy === e_busy) && (cmd_ready === e_cr) && (fill_ready === e_fr);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got wen=%b waddr=%h wdata=%h ren=%b saddr=%h busy=%b crdy=%b frdy=%b ; want wen=%b waddr=%h wdata=%h ren=%b saddr=%h busy=%b crdy=%b frdy=%b",
                     tag, wen, waddr, wdata, src_ren, src_addr, busy, cmd_ready, fill_ready,
                     e_wen, e_waddr, e_wdata, e_ren, e_saddr, e_busy, e_cr, e_fr);
        end
    endtask

    task automatic check_count(input string tag, input int nwr, input logic [15:0] first,
                               input int exp_nwr, input logic [15:0] exp_first);
        n_tests++;
        if (nwr != exp_nwr || (exp_nwr != 0 && first !== exp_first)) begin
            n_fail++;
            $display("FAIL %s: got %0d writes first=%0d ; want %0d writes first=%0d",
                     tag, nwr, first, exp_nwr, exp_first);
        end
    endtask

    // Starts in the accept cycle T (just after a negedge), ends in cycle T+7.
    task automatic do_spr(input logic [3:0] idx, input logic [15:0] fstep,
                          output int nwr, output logic [15:0] first);
        logic [15:0] f [6];
        bit          legal;
        logic        e;
        int          j;
        for (int q = 0; q < 6; q++) f[q] = 16'(fstep * (q + 1));
        legal     = (idx < 4'd10);
        cmd_valid = 1'b1;
        cmd_index = idx;
        cmd_sx = f[0]; cmd_sy = f[1]; cmd_stx = f[2];
        cmd_sty = f[3]; cmd_stw = f[4]; cmd_sth = f[5];
        #1;
        step_check($sformatf("spr%0d_accept", idx), 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
        nwr   = 0;
        first = '0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            e = legal && (k <= 6);
            j = (k <= 6) ? k - 1 : 0;
            step_check($sformatf("spr%0d_k%0d", idx, k), e, 16'(idx * 6 + k - 1), f[j],
                       1'b0, 16'h0, e);
            if (wen === 1'b1) begin
                if (nwr == 0) first = waddr;
                nwr++;
            end
        end
    endtask

    // Starts in the accept cycle T, ends in cycle T+len+3. rst_k / vb_drop_k
    // (0 = unused) assert reset or drop vblank in relative cycle k.
    task automatic do_fill(input logic [12:0] base, input logic [12:0] len, input logic [15:0] src,
                           input int rst_k, input int vb_drop_k,
                           output int nwr, output logic [15:0] first);
        int   lenI, i;
        bit   act, wv;
        logic e_ren, e_wen, e_busy;
        logic [15:0] e_saddr, e_waddr, e_wdata;
        lenI       = int'(len);
        act        = (lenI != 0);
        fill_valid = 1'b1;
        fill_base  = base;
        fill_len   = len;
        fill_src   = src;
        #1;
        step_check($sformatf("fill_b%0d_accept", base), 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
        nwr   = 0;
        first = '0;
        for (int k = 1; k <= lenI + 3; k++) begin
            @(negedge clk);
            fill_valid = 1'b0;
            rst        = (k == rst_k);
            if (vb_drop_k != 0 && k == vb_drop_k) vblank = 1'b0;
            #1;
            i       = k - 3;
            e_ren   = act && (k <= lenI);
            e_saddr = 16'(int'(src) + k - 1);
            wv      = act && (i >= 0) && (i < lenI);
            e_wen   = wv && ((int'(base) + i) < 4096);
            e_waddr = 16'(60 + int'(base) + i);
            e_wdata = 16'('hA00 + ((int'(src) + i) & 'hFF));
            e_busy  = act && (k <= lenI + 2);
            if (rst_k != 0 && k > rst_k) begin
                e_ren = 1'b0; e_wen = 1'b0; e_busy = 1'b0;
            end
            step_check($sformatf("fill_b%0d_k%0d", base, k), e_wen, e_waddr, e_wdata,
                       e_ren, e_saddr, e_busy);
            if (wen === 1'b1) begin
                if (nwr == 0) first = waddr;
                nwr++;
            end
        end
        rst = 1'b0;
    endtask

    vec_t        tbl [9];
    int          nwr;
    logic [15:0] first;

    initial begin
        //            fill idx    fstep     base      len    src       nwr first
        tbl[0] = '{1'b0, 4'd3,  16'd10,   13'd0,    13'd0, 16'h0000, 6, 16'd18};
        tbl[1] = '{1'b1, 4'd0,  16'd0,    13'd5,    13'd4, 16'h0100, 4, 16'd65};
        tbl[2] = '{1'b1, 4'd0,  16'd0,    13'd4094, 13'd4, 16'h0200, 2, 16'd4154};
        tbl[3] = '{1'b1, 4'd0,  16'd0,    13'd7,    13'd0, 16'h0300, 0, 16'd0};
        tbl[4] = '{1'b0, 4'd12, 16'd5,    13'd0,    13'd0, 16'h0000, 0, 16'd0};
        tbl[5] = '{1'b0, 4'd9,  16'd1,    13'd0,    13'd0, 16'h0000, 6, 16'd54};
        tbl[6] = '{1'b0, 4'd0,  16'h1111, 13'd0,    13'd0, 16'h0000, 6, 16'd0};
        tbl[7] = '{1'b1, 4'd0,  16'd0,    13'd0,    13'd3, 16'hFFFE, 3, 16'd60};
        tbl[8] = '{1'b1, 4'd0,  16'd0,    13'd8190, 13'd3, 16'h0010, 0, 16'd0};

        rst = 1'b1; vblank = 1'b0; cmd_valid = 1'b0; fill_valid = 1'b0;
        cmd_index = '0; cmd_sx = '0; cmd_sy = '0; cmd_stx = '0;
        cmd_sty = '0; cmd_stw = '0; cmd_sth = '0;
        fill_base = '0; fill_len = '0; fill_src = '0;

        repeat (3) @(negedge clk);
        #1;
        step_check("reset", 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
        n_tests++;
        if (waddr !== 16'h0 || wdata !== 16'h0 || src_addr !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got waddr=%h wdata=%h src_addr=%h ; want all 0",
                     waddr, wdata, src_addr);
        end

        @(negedge clk);
        rst    = 1'b0;
        vblank = 1'b1;

        foreach (tbl[v]) begin
            if (tbl[v].is_fill)
                do_fill(tbl[v].base, tbl[v].len, tbl[v].src, 0, 0, nwr, first);
            else
                do_spr(tbl[v].idx, tbl[v].fstep, nwr, first);
            check_count($sformatf("vec%0d_writes", v), nwr, first, tbl[v].exp_nwr, tbl[v].exp_first);
        end

        // Priority and vblank gating: both pending while vblank is low.
        @(negedge clk);
        vblank     = 1'b0;
        cmd_valid  = 1'b1;
        cmd_index  = 4'd4;
        fill_valid = 1'b1;
        fill_base  = 13'd100;
        fill_len   = 13'd2;
        fill_src   = 16'h0040;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            step_check($sformatf("gated_c%0d", c), 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
        end
        vblank = 1'b1;
        do_spr(4'd4, 16'd7, nwr, first);
        check_count("prio_spr_writes", nwr, first, 6, 16'd24);
        // fill_valid stayed high through the sprite; it is taken right after.
        do_fill(13'd100, 13'd2, 16'h0040, 0, 1, nwr, first);
        check_count("prio_fill_writes", nwr, first, 2, 16'd160);

        // Reset during the third read of a len=8 fill.
        @(negedge clk);
        vblank = 1'b1;
        #1;
        do_fill(13'd20, 13'd8, 16'h0050, 3, 0, nwr, first);
        check_count("rst_fill_writes", nwr, first, 1, 16'd80);
        do_spr(4'd2, 16'd3, nwr, first);
        check_count("post_rst_spr_writes", nwr, first, 6, 16'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cluster_write_ctrl.md
Name: cluster_write_ctrl

Overview:
- Write-port sequencer for one sprite cluster.
- Converts two kinds of high-level command into the cluster's single-word write bus (waddr/wdata/wen):
  - sprite-descriptor updates (6 words each);
  - texture block fills, streamed from a source memory.
- Writes only start during vertical blanking, so the display never sees a half-updated sprite.
- Sits between the CPU-facing GPU register block and the cluster.

Parameters:
CLUSTER_SIZE, 10, number of sprites in the cluster
TEXTURE_SIZE, 4096, texture words in the cluster (width*height)
ADDR_WIDTH, 16, cluster write-address width
INT_WIDTH, 16, sprite field / data width
COLOR_WIDTH, 12, texel width
LEN_WIDTH, 13, width of fill length / base fields

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
vblank  in  1  high while the display is outside the visible area
cmd_valid  in  1  sprite command valid
cmd_ready  out  1  sprite command accepted when valid&ready
cmd_index  in  $clog2(CLUSTER_SIZE)  sprite slot
cmd_sx, cmd_sy, cmd_stx, cmd_sty, cmd_stw, cmd_sth  in  INT_WIDTH each  descriptor fields
fill_valid  in  1  texture fill command valid
fill_ready  out  1  fill accepted when valid&ready
fill_base  in  LEN_WIDTH  first texture offset
fill_len  in  LEN_WIDTH  number of texels
fill_src  in  ADDR_WIDTH  source start address
src_addr  out  ADDR_WIDTH  source memory read address
src_ren  out  1  source read enable
src_rdata  in  COLOR_WIDTH  source data, valid the cycle after src_ren
waddr  out  ADDR_WIDTH  cluster write address
wdata  out  INT_WIDTH  cluster write data
wen  out  1  cluster write enable
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset:
  - state=IDLE; waddr, wdata, wen, src_addr, src_ren = 0; busy=0.
  - Reset mid-command abandons the command; no further writes occur.
- Cluster address map:
  - Sprite field f of slot n is written at n*6+f.
  - Field order f = 0..5: sx, sy, stx, sty, stw, sth.
  - Texel at offset t is written at CLUSTER_SIZE*6 + t.
- Handshake:
  - cmd_ready = (state==IDLE) & vblank.
  - fill_ready = (state==IDLE) & vblank & ~cmd_valid, i.e. fixed priority to sprite commands.
  - Both ready signals are combinational; valid must not depend on ready.
- States:
  - IDLE, SPR, FILL, DRAIN.
  - IDLE -> SPR on cmd accept.
  - IDLE -> FILL on fill accept with fill_len != 0.
  - A fill with fill_len=0 is accepted and stays in IDLE; no writes occur.
- SPR:
  - Fields are latched at accept (cycle T).
  - Registered outputs: in cycle T+1+k (k = 0..5), wen=1, waddr=index*6+k, wdata=field k.
  - Returns to IDLE after k=5; cmd_ready can next be high in T+7.
- FILL (source RAM has 1-cycle read latency; writes are registered):
  - Source read i, for i = 0..len-1: src_ren=1 and src_addr=fill_src+i in cycle T+1+i.
  - Cluster write i: in cycle T+3+i, wen=1, waddr=CLUSTER_SIZE*6+fill_base+i, wdata=zero-extended src_rdata.
  - After the last read, FILL -> DRAIN; DRAIN lasts 2 cycles, then -> IDLE.
  - Last write occurs at T+2+len; fill_ready can next be high in T+3+len.
- Clipping: any write whose texel offset fill_base+i >= TEXTURE_SIZE is suppressed (wen=0). Sequence timing is unchanged.
- Offset arithmetic:
  - fill_base+i is computed at LEN_WIDTH+1 bits, so it does not wrap.
  - src_addr wraps modulo 2^ADDR_WIDTH.
- vblank:
  - Gates only the start of a command; a started command always completes, even if vblank falls.
- wen is 0 in every cycle not listed above; waddr and wdata hold their last value when wen=0.
- Illegal cmd_index >= CLUSTER_SIZE: command is accepted and dropped; no writes, state stays IDLE.

Decomposition:
- Package gpu_pkg:
  - state enum cluster_wr_state_t;
  - SPRITE_FIELDS=6;
  - field-index constants F_SX..F_STH;
  - function texture_base(cluster_size) returning cluster_size*SPRITE_FIELDS.
- Single module, no sub-module. The fill path (read counter plus 2-stage valid/offset pipeline) is kept inline.

Test Plan:
- Sprite write: vblank=1, cmd index=3, fields 10,20,30,40,50,60 -> wen for 6 consecutive cycles, waddr 18..23, wdata 10..60; busy high for those cycles.
- Fill: base=5, len=4, src=0x100, source RAM holds 0xA00+addr -> src_addr 0x100..0x103; writes waddr 65..68 with data 0xA00..0xA03, 2 cycles after each read.
- Priority and gating: both valid while vblank=0 -> no accept. Raise vblank -> sprite accepted first, fill accepted in the cycle after the sprite's last write; vblank dropped mid-fill -> fill still completes.
- Boundaries:
  - fill base=4094, len=4 -> only writes at 60+4094 and 60+4095; the 4-cycle read stream is unchanged.
  - len=0 -> accepted, no wen, busy stays 0.
  - cmd_index=12 -> no wen.
- Reset mid-fill: rst for 1 cycle during the 3rd read of a len=8 fill -> next cycle wen=0, src_ren=0, busy=0; a new sprite command is then accepted and executes normally.
